// File: rtl/freq_div_pkg.sv
// Shared constants, helpers and channel action encoding for the multi-channel frequency divider.
package freq_div_pkg;

    localparam int DIV_WIDTH_DEF   = 16;
    localparam int DEFAULT_DIV_DEF = 2;

    // What a channel does on the coming edge, in priority order below reset.
    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_WRAP  = 2'd2,
        ACT_SYNC  = 2'd3
    } ch_action_e;

    function automatic int clog2(input int value);
        int result = 0;
        int rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    function automatic int index_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: period counter, single-entry pending divisor slot and registered outputs.
module divider_channel
    import freq_div_pkg::*;
#(
    parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 enable,
    input  logic                 sync,
    input  logic                 load_strobe,
    input  logic [DIV_WIDTH-1:0] load_value,
    output logic                 pending,
    output logic                 clock_division,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_div, r_count, r_pend_val;
    logic                 r_pending, r_clock_division, r_tick;

    logic [DIV_WIDTH-1:0] w_div_next, w_count_next, w_pend_val_next, w_div_apply;
    logic                 w_pending_next, w_clock_division_next, w_tick_next;
    logic                 w_active, w_active_apply;
    ch_action_e           w_action;

    function automatic logic [DIV_WIDTH-1:0] high_len(input logic [DIV_WIDTH-1:0] d);
        return d - (d >> 1);
    endfunction

    always_comb begin
        w_div_apply    = r_pending ? r_pend_val : r_div;
        w_active       = enable && (r_div != '0);
        w_active_apply = enable && (w_div_apply != '0);
        if (sync)                         w_action = ACT_SYNC;
        else if (!w_active)               w_action = ACT_IDLE;
        else if (r_count == r_div - ONE)  w_action = ACT_WRAP;
        else                              w_action = ACT_COUNT;
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        w_div_next            = r_div;
        w_count_next          = r_count;
        w_pend_val_next       = r_pend_val;
        w_pending_next        = r_pending;
        w_clock_division_next = 1'b0;
        w_tick_next           = 1'b0;
        unique case (w_action)
            ACT_SYNC, ACT_WRAP: begin
                w_div_next            = w_div_apply;
                w_pending_next        = 1'b0;
                w_count_next          = '0;
                w_clock_division_next = w_active_apply;
                w_tick_next           = w_active_apply;
            end
            ACT_COUNT: begin
                w_count_next          = r_count + ONE;
                w_clock_division_next = (r_count + ONE) < high_len(r_div);
            end
            ACT_IDLE: begin
                if (r_pending) begin
                    w_div_next     = r_pend_val;
                    w_count_next   = '0;
                    w_pending_next = 1'b0;
                end
            end
            default: ;
        endcase
        // A load on a boundary edge only fills the slot; it is applied at the next boundary.
        if (load_strobe) begin
            w_pend_val_next = load_value;
            w_pending_next  = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_div            <= DIV_WIDTH'(DEFAULT_DIV);
            r_count          <= DIV_WIDTH'(DEFAULT_DIV - 1);
            r_pend_val       <= '0;
            r_pending        <= 1'b0;
            r_clock_division <= 1'b0;
            r_tick           <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge state together.
            r_div            <= w_div_next;
            r_count          <= w_count_next;
            r_pend_val       <= w_pend_val_next;
            r_pending        <= w_pending_next;
            r_clock_division <= w_clock_division_next;
            r_tick           <= w_tick_next;
        end
    end

    assign pending        = r_pending;
    assign clock_division = r_clock_division;
    assign tick           = r_tick;

endmodule

// File: rtl/multi_frequency_divider.sv
// CHANNELS independent programmable clock dividers sharing one divisor-load port and a global sync.
module multi_frequency_divider
    import freq_div_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = index_width(CHANNELS)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Div_load_valid,
    input  logic [CH_W-1:0]      Div_load_channel,
    input  logic [DIV_WIDTH-1:0] Div_load_value,
    output logic                 Div_load_ready,
    input  logic [CHANNELS-1:0]  Enable,
    input  logic                 Sync,
    output logic [CHANNELS-1:0]  Clock_division,
    output logic [CHANNELS-1:0]  Tick
);

    logic [CHANNELS-1:0] w_pending;
    logic [CHANNELS-1:0] w_load_strobe;

    // Out-of-range channel numbers stay ready and are silently dropped.
    always_comb begin
        Div_load_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (Div_load_channel == CH_W'(i)) Div_load_ready = !w_pending[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_load_strobe[g] = Div_load_valid && Div_load_ready
                                  && (Div_load_channel == CH_W'(g));

        divider_channel #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .Clock          (Clock),
            .Reset          (Reset),
            .enable         (Enable[g]),
            .sync           (Sync),
            .load_strobe    (w_load_strobe[g]),
            .load_value     (Div_load_value),
            .pending        (w_pending[g]),
            .clock_division (Clock_division[g]),
            .tick           (Tick[g])
        );
    end

endmodule

// File: tb/tb_multi_frequency_divider.sv
// Self-checking bench: hand-derived vector table replayed through a scoreboard queue, plus reset sequences.
module tb_multi_frequency_divider;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Div_load_valid = 1'b0;
    logic [1:0]  Div_load_channel = 2'd0;
    logic [15:0] Div_load_value = 16'd0;
    logic        Div_load_ready;
    logic [3:0]  Enable = 4'b0000;
    logic        Sync = 1'b0;
    logic [3:0]  Clock_division;
    logic [3:0]  Tick;

    always #10 Clock = ~Clock;

    multi_frequency_divider #(
        .CHANNELS    (4),
        .DIV_WIDTH   (16),
        .DEFAULT_DIV (2)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Div_load_valid   (Div_load_valid),
        .Div_load_channel (Div_load_channel),
        .Div_load_value   (Div_load_value),
        .Div_load_ready   (Div_load_ready),
        .Enable           (Enable),
        .Sync             (Sync),
        .Clock_division   (Clock_division),
        .Tick             (Tick)
    );

    typedef struct {
        logic [3:0]  en;
        logic        sync;
        logic        lv;
        logic [1:0]  lch;
        logic [15:0] lval;
        logic        rdy;
        logic [3:0]  cd;
        logic [3:0]  tk;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] cd;
        logic [3:0] tk;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic [3:0] en, input logic sync, input logic lv,
                       input logic [1:0] lch, input logic [15:0] lval, input logic rdy,
                       input logic [3:0] cd, input logic [3:0] tk);
        vec_t v;
        v.en = en; v.sync = sync; v.lv = lv; v.lch = lch; v.lval = lval;
        v.rdy = rdy; v.cd = cd; v.tk = tk;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ch0 at D=2 after reset, then ch1 loaded to D=5 on a wrap edge
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0001);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0001);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0010, 0, 1, 2'd1, 16'd5, 1, 4'b0010, 4'b0010);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 0, 4'b0000, 4'b0000);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 0, 4'b0010, 4'b0010);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 1, 4'b0010, 4'b0000);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 1, 4'b0010, 4'b0000);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 1, 4'b0010, 4'b0010);
        add(4'b0010, 0, 0, 2'd1, 16'd0, 1, 4'b0010, 4'b0000);
        // ch2: D=3 loaded on a wrap, second load stalled two cycles, then D=6
        add(4'b0100, 0, 1, 2'd2, 16'd3, 1, 4'b0100, 4'b0100);
        add(4'b0100, 0, 1, 2'd2, 16'd6, 0, 4'b0000, 4'b0000);
        add(4'b0100, 0, 1, 2'd2, 16'd6, 0, 4'b0100, 4'b0100);
        add(4'b0100, 0, 1, 2'd2, 16'd6, 1, 4'b0100, 4'b0000);
        add(4'b0100, 0, 0, 2'd2, 16'd0, 0, 4'b0000, 4'b0000);
        add(4'b0100, 0, 0, 2'd2, 16'd0, 0, 4'b0100, 4'b0100);
        // ch3 loaded D=4 while disabled, both run out of phase, then Sync
        add(4'b0100, 0, 1, 2'd3, 16'd4, 1, 4'b0100, 4'b0000);
        add(4'b0100, 0, 0, 2'd3, 16'd0, 0, 4'b0100, 4'b0000);
        add(4'b1100, 0, 0, 2'd3, 16'd0, 1, 4'b1000, 4'b0000);
        add(4'b1100, 0, 0, 2'd3, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b1100, 1, 0, 2'd3, 16'd0, 1, 4'b1100, 4'b1100);
        add(4'b1100, 0, 0, 2'd3, 16'd0, 1, 4'b1100, 4'b0000);
        add(4'b1100, 0, 0, 2'd3, 16'd0, 1, 4'b0100, 4'b0000);
        // ch3 D=1 then D=0
        add(4'b1000, 0, 1, 2'd3, 16'd1, 1, 4'b0000, 4'b0000);
        add(4'b1000, 0, 0, 2'd3, 16'd0, 0, 4'b1000, 4'b1000);
        add(4'b1000, 0, 0, 2'd3, 16'd0, 1, 4'b1000, 4'b1000);
        add(4'b1000, 0, 1, 2'd3, 16'd0, 1, 4'b1000, 4'b1000);
        add(4'b1000, 0, 0, 2'd3, 16'd0, 0, 4'b0000, 4'b0000);
        add(4'b1000, 0, 0, 2'd3, 16'd0, 1, 4'b0000, 4'b0000);
        // ch0 D=6, paused for three cycles during the high phase
        add(4'b0000, 0, 1, 2'd0, 16'd6, 1, 4'b0000, 4'b0000);
        add(4'b0000, 0, 0, 2'd0, 16'd0, 0, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0001);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0000);
        add(4'b0000, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0000, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0000, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0000, 4'b0000);
        add(4'b0001, 0, 0, 2'd0, 16'd0, 1, 4'b0001, 4'b0001);

        // Power-on reset, short run, then an asynchronous reset mid-run.
        repeat (3) @(negedge Clock);
        check("por outputs", {Clock_division, Tick}, 8'h00);
        Reset  = 1'b0;
        Enable = 4'b0001;
        @(posedge Clock); #1;
        check("first edge after por", {Clock_division, Tick}, 8'h11);
        @(posedge Clock); #1;
        check("d2 low phase", {Clock_division, Tick}, 8'h00);
        @(posedge Clock); #1;
        check("d2 high phase", {Clock_division, Tick}, 8'h11);
        #4 Reset = 1'b1;
        #1;
        check("async reset outputs", {Clock_division, Tick}, 8'h00);
        check("async reset ready", {31'd0, Div_load_ready}, 32'd1);
        @(negedge Clock);
        Reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            exp_t e;
            Enable           = vecs[k].en;
            Sync             = vecs[k].sync;
            Div_load_valid   = vecs[k].lv;
            Div_load_channel = vecs[k].lch;
            Div_load_value   = vecs[k].lval;
            #1;
            check($sformatf("v%0d ready", k + 1), {31'd0, Div_load_ready}, {31'd0, vecs[k].rdy});
            e.idx = k + 1;
            e.cd  = vecs[k].cd;
            e.tk  = vecs[k].tk;
            sb.push_back(e);
            @(posedge Clock); #1;
            e = sb.pop_front();
            check($sformatf("v%0d clock_division", e.idx), {28'd0, Clock_division}, {28'd0, e.cd});
            check($sformatf("v%0d tick", e.idx), {28'd0, Tick}, {28'd0, e.tk});
            @(negedge Clock);
        end
        Div_load_valid = 1'b0;
        Sync           = 1'b0;

        check("scoreboard drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_frequency_divider.md
Name: multi_frequency_divider

Overview:
- Parametrised successor to the single fixed-ratio frequency divider.
- Generates CHANNELS independent divided clocks from one system Clock. Each channel has a runtime-programmable divisor, a per-channel enable, a one-cycle Tick strobe and a global phase-align Sync.
- Sits between the board clock and the game timing logic: display refresh, game-step, debounce and blink rates.

Parameters:
- CHANNELS, 4, number of independent divider channels (>=1).
- DIV_WIDTH, 16, width of each divisor and counter.
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (2 <= DEFAULT_DIV < 2^DIV_WIDTH).
- CH_W, max(1,clog2(CHANNELS)), derived localparam for the channel index width.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Div_load_valid  in  1  request to load a new divisor.
- Div_load_channel  in  CH_W  target channel of the load.
- Div_load_value  in  DIV_WIDTH  new divisor D.
- Div_load_ready  out  1  combinational: !pending[Div_load_channel]. Load is accepted on an edge with valid && ready.
- Enable  in  CHANNELS  per-channel run enable.
- Sync  in  1  phase-align all channels to period start.
- Clock_division  out  CHANNELS  registered divided clock per channel.
- Tick  out  CHANNELS  registered one-cycle pulse at each period start.

Behaviour:
- Per-channel state: div (DIV_WIDTH), count (DIV_WIDTH), pend_val (DIV_WIDTH), pending (1), Clock_division (1), Tick (1).
- Define H = D - floor(D/2), the high-phase length. The channel is active iff Enable[i] && div != 0.
- Reset (async):
  - div = DEFAULT_DIV, count = DEFAULT_DIV-1, pending = 0, pend_val = 0.
  - Clock_division = 0, Tick = 0.
  - The first active edge after release therefore wraps to count 0.
- Priority per channel, per edge: Reset > Sync > wrap/apply > count > hold.
- Active, count != div-1: count <= count+1; Clock_division <= (count+1 < H); Tick <= 0.
- Active, count == div-1 (wrap):
  - If pending: div <= pend_val, pending <= 0, and H is taken from the new divisor.
  - count <= 0; Clock_division <= 1; Tick <= 1.
  - Exception: if the newly applied divisor is 0, the channel goes inactive and the inactive rules apply.
- Inactive (Enable low or div == 0):
  - count holds; Clock_division <= 0; Tick <= 0.
  - If pending: div <= pend_val, count <= 0, pending <= 0, taking effect on the next edge.
- Sync = 1, all channels:
  - Apply pending if set; count <= 0.
  - Clock_division <= active'; Tick <= active'. active' is evaluated with the post-apply divisor.
- Load accept: pend_val <= Div_load_value, pending <= 1.
  - A load accepted on the same edge as a wrap or Sync is stored in pending only. It is applied at the next boundary, never retroactively.
  - A second load to a channel with pending = 1 is stalled (ready = 0).
  - Div_load_channel >= CHANNELS: ready = 1, request accepted and discarded.
- Boundary divisors:
  - D = 1: count stays 0; Clock_division constant 1; Tick every cycle.
  - D = 2: Clock_division toggles every cycle.
  - D = 2^DIV_WIDTH-1: no overflow; count max equals div-1.
- Re-enable after a pause: resumes from the held count. Clock_division follows (count+1 < H) from the first active edge.
- Outputs are driven only from flops: glitch-free and safe to use as clock-enables.
- Latency: a divisor change appears at the first period boundary after acceptance. The old period always completes, so no runt pulses occur.

Decomposition:
- Shared package (freq_div_pkg):
  - clog2 function.
  - Constants DIV_WIDTH_DEF = 16, DEFAULT_DIV_DEF = 2.
  - Channel-state field widths.
- Sub-module divider_channel: one channel's counter, pending slot and output flops, with ports Clock, Reset, enable, sync, load_strobe, load_value, pending, clock_division, tick. It is instantiated CHANNELS times via generate.
- The top level holds only the load decode and the ready mux.

Test Plan:
1. Reset pulse mid-run (Clock period 20 ns) -> all Clock_division/Tick = 0 immediately, Div_load_ready = 1; first edge after release: Tick[0] = 1, Clock_division[0] = 1, then toggles every cycle (D = 2).
2. Load ch1 D = 5, Enable = 4'b0010 -> after the current period ends: Clock_division[1] pattern 1,1,1,0,0 repeating; Tick[1] every 5th cycle.
3. Load ch2 D = 3 mid-period, then a second load with ready = 0 held 2 cycles -> old period finishes; new period 1,1,0; second load accepted only after the apply edge.
4. Channels with D = 4 and 6 at random phases, pulse Sync -> next edge: all enabled channels show Tick = 1 and Clock_division = 1 simultaneously.
5. D = 1 on ch3 -> Clock_division[3] constant 1, Tick[3] every cycle. Then load D = 0 -> channel outputs 0 after the boundary.
6. Drop Enable[0] for 3 cycles during the high phase (D = 6) -> output 0 and count frozen. On re-enable, resumes at the remaining phase with no extra Tick.
